// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 access-size codes,
// ResultSrc select values and the memory FSM state type.
package mem_pkg;

  localparam int XLEN = 32;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_GNT = 2'b01,
    WAIT_RSP = 2'b10
  } state_t;

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed byte/half out of a returned load word
// and sign- or zero-extends it according to funct3.
// Ports:
//   rdata  - raw 32-bit word from data memory
//   addr   - byte offset within the word captured at request time
//   funct3 - load size/sign code
//   data   - extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin
    shifted  = rdata >> {addr, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the 5-stage RISC-V pipeline. Issues data
// memory requests with store byte-lane steering, extracts/extends load
// data, registers the E (writeback) stage and stalls upstream while a
// memory transaction is outstanding.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   *D inputs                        - execute-stage D registers
//   ForwardALUResultDH               - ALUResultD copy for forwarding
//   StallMemH / MemFaultH            - upstream stall, misalignment/illegal pulse
//   dmem_*                           - data memory request/response
//   *E outputs                       - writeback-stage registers
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction outstanding; new op may request this cycle
// WAIT_GNT | request presented, waiting for dmem_ready
// WAIT_RSP | load granted, waiting for dmem_rvalid
module mem_access
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [4:0]            RdD,
  input  logic [DATA_WIDTH-1:0] MemWriteDataD,
  input  logic [DATA_WIDTH-1:0] ALUResultD,
  input  logic [2:0]            Funct3D,
  output logic [DATA_WIDTH-1:0] ForwardALUResultDH,
  output logic                  StallMemH,
  output logic                  MemFaultH,
  output logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [STRB_WIDTH-1:0] dmem_wstrb,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic [4:0]            RdE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [DATA_WIDTH-1:0] ALUResultE,
  output logic [DATA_WIDTH-1:0] ReadDataE
);

  state_t state, state_nxt;

  logic                  is_store, is_load, mem_op, legal;
  logic                  req, stall, fault, grant, complete, load_done;
  logic [1:0]            lane_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] wdata_steer;
  logic [STRB_WIDTH-1:0] wstrb_steer;

  // A store wins if both flags are set; such an op is never treated as a load.
  assign is_store = MemWriteD;
  assign is_load  = (ResultSrcD == RES_LOAD) && !MemWriteD;
  assign mem_op   = is_store || is_load;

  always_comb begin
    legal = 1'b0;
    if (is_store) begin
      case (Funct3D)
        F3_SB:   legal = 1'b1;
        F3_SH:   legal = !ALUResultD[0];
        F3_SW:   legal = (ALUResultD[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else if (is_load) begin
      case (Funct3D)
        F3_LB, F3_LBU: legal = 1'b1;
        F3_LH, F3_LHU: legal = !ALUResultD[0];
        F3_LW:         legal = (ALUResultD[1:0] == 2'b00);
        default:       legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    wdata_steer = MemWriteDataD;
    wstrb_steer = '0;
    if (is_store) begin
      case (Funct3D[1:0])
        2'b00: begin
          wdata_steer = {4{MemWriteDataD[7:0]}};
          wstrb_steer = 4'b0001 << ALUResultD[1:0];
        end
        2'b01: begin
          wdata_steer = {2{MemWriteDataD[15:0]}};
          wstrb_steer = 4'b0011 << ALUResultD[1:0];
        end
        default: begin
          wdata_steer = MemWriteDataD;
          wstrb_steer = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    fault     = 1'b0;
    grant     = 1'b0;
    complete  = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !legal) begin
          fault = 1'b1;
        end else if (mem_op) begin
          req = 1'b1;
          if (dmem_ready) begin
            grant = 1'b1;
            if (is_store) complete  = 1'b1;
            else          state_nxt = WAIT_RSP;
          end else begin
            state_nxt = WAIT_GNT;
          end
          stall = !complete;
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_ready) begin
          grant = 1'b1;
          if (is_store) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_RSP;
          end
        end
        stall = !complete;
      end
      WAIT_RSP: begin
        // rvalid is only honoured here, so it can never coincide with the grant.
        if (dmem_rvalid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_nxt = IDLE;
        end
        stall = !complete;
      end
      default: state_nxt = IDLE;
    endcase
    // Keep the handshake and hazard outputs quiet while reset is held.
    if (!rst_n) begin
      state_nxt = IDLE;
      req       = 1'b0;
      stall     = 1'b0;
      fault     = 1'b0;
      grant     = 1'b0;
      complete  = 1'b0;
      load_done = 1'b0;
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (lane_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane_q     <= '0;
      f3_q       <= '0;
      RegWriteE  <= 1'b0;
      ResultSrcE <= '0;
      RdE        <= '0;
      PCPlus4E   <= '0;
      ALUResultE <= '0;
      ReadDataE  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        lane_q <= ALUResultD[1:0];
        f3_q   <= Funct3D;
      end
      PCPlus4E   <= PCPlus4D;
      ALUResultE <= ALUResultD;
      if (stall || fault) begin
        RegWriteE  <= 1'b0;
        RdE        <= '0;
        ResultSrcE <= RES_ALU;
      end else begin
        RegWriteE  <= RegWriteD;
        RdE        <= RdD;
        ResultSrcE <= ResultSrcD;
      end
      if (load_done) ReadDataE <= load_data;
    end
  end

  assign ForwardALUResultDH = ALUResultD;
  assign StallMemH          = stall;
  assign MemFaultH          = fault;
  assign dmem_req           = req;
  assign dmem_we            = is_store;
  assign dmem_addr          = {ALUResultD[DATA_WIDTH-1:2], 2'b00};
  assign dmem_wdata         = wdata_steer;
  assign dmem_wstrb         = wstrb_steer;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: drives one instruction at a time,
// plays the memory side with configurable grant/response delays and
// checks the writeback registers against a scoreboard queue.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteD;
  logic [1:0]  ResultSrcD;
  logic        MemWriteD;
  logic [31:0] PCPlus4D;
  logic [4:0]  RdD;
  logic [31:0] MemWriteDataD;
  logic [31:0] ALUResultD;
  logic [2:0]  Funct3D;
  logic [31:0] ForwardALUResultDH;
  logic        StallMemH;
  logic        MemFaultH;
  logic        dmem_req;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  RdE;
  logic [31:0] PCPlus4E;
  logic [31:0] ALUResultE;
  logic [31:0] ReadDataE;

  always #5 clk = ~clk;

  mem_access #(.DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .PCPlus4D(PCPlus4D), .RdD(RdD), .MemWriteDataD(MemWriteDataD),
    .ALUResultD(ALUResultD), .Funct3D(Funct3D),
    .ForwardALUResultDH(ForwardALUResultDH), .StallMemH(StallMemH), .MemFaultH(MemFaultH),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdE(RdE),
    .PCPlus4E(PCPlus4E), .ALUResultE(ALUResultE), .ReadDataE(ReadDataE)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // kind: 0 ALU op, 1 load, 2 store, 3 PC+4 op.
  // gnt_dly: cycles with ready=0 before the grant; rsp_dly: WAIT_RSP cycles before rvalid.
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] pc4,
                        input int gnt_dly, input int rsp_dly, input logic [31:0] rword,
                        input logic exp_fault, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    exp_t e;
    int   ph, g, r, cyc;
    logic mem, done, comp;
    RegWriteD     = (kind != 2);
    ResultSrcD    = (kind == 1) ? 2'b01 : ((kind == 3) ? 2'b10 : 2'b00);
    MemWriteD     = (kind == 2);
    PCPlus4D      = pc4;
    RdD           = rd;
    MemWriteDataD = sdata;
    ALUResultD    = addr;
    Funct3D       = f3;
    mem = (kind == 1) || (kind == 2);
    if (mem && exp_fault) e = '{1'b0, 5'd0, 2'b00, addr, pc4, last_rdata};
    else e = '{RegWriteD, rd, ResultSrcD, addr, pc4, (kind == 1) ? exp_rdata : last_rdata};
    sb.push_back(e);
    ph = 0; g = 0; r = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 30) begin
      dmem_ready  = (ph == 0) && (g >= gnt_dly);
      dmem_rvalid = (ph == 1) && (r >= rsp_dly);
      dmem_rdata  = dmem_rvalid ? rword : 32'h0BAD_F00D;
      #1;
      comp = !mem || exp_fault || (kind == 2 && dmem_ready) || (kind == 1 && dmem_rvalid);
      check_val("fault", MemFaultH, mem && exp_fault);
      check_val("stall", StallMemH, mem && !exp_fault && !comp);
      check_val("req", dmem_req, mem && !exp_fault && ph == 0);
      check_val("fwd", ForwardALUResultDH, addr);
      if (mem && !exp_fault && ph == 0) begin
        check_val("addr", dmem_addr, {addr[31:2], 2'b00});
        check_val("we", dmem_we, kind == 2);
        check_val("wstrb", dmem_wstrb, (kind == 2) ? exp_strb : 4'b0000);
        if (kind == 2) check_val("wdata", dmem_wdata, exp_wdata);
      end
      @(posedge clk); #1;
      if (comp) begin
        e = sb.pop_front();
        check_val("RegWriteE", RegWriteE, e.rw);
        check_val("RdE", RdE, e.rd);
        check_val("ResultSrcE", ResultSrcE, e.rs);
        check_val("ALUResultE", ALUResultE, e.alu);
        check_val("PCPlus4E", PCPlus4E, e.pc4);
        check_val("ReadDataE", ReadDataE, e.rdata);
        last_rdata = e.rdata;
        done = 1'b1;
      end else begin
        check_val("bubble_rw", RegWriteE, 1'b0);
        check_val("bubble_rd", RdE, 5'd0);
        if (ph == 0 && dmem_ready) ph = 1;
        else if (ph == 0) g++;
        else r++;
      end
      cyc++;
    end
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    if (!done) check_val("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset held with a legal load present: handshake outputs must stay low.
    rst_n = 1'b0; dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
    RegWriteD = 1'b1; ResultSrcD = 2'b01; MemWriteD = 1'b0; PCPlus4D = 32'h4;
    RdD = 5'd3; MemWriteDataD = '0; ALUResultD = 32'h40; Funct3D = 3'b010;
    last_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", dmem_req, 1'b0);
    check_val("rst_stall", StallMemH, 1'b0);
    check_val("rst_fault", MemFaultH, 1'b0);
    check_val("rst_rw", RegWriteE, 1'b0);
    check_val("rst_alu", ALUResultE, 32'h0);
    check_val("rst_rdata", ReadDataE, 32'h0);
    rst_n = 1'b1; dmem_ready = 1'b0;

    // Stores
    run_op(2, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h1004, 0, 0, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_op(2, 3'b000, 32'h103, 32'h000000A5, 5'd0, 32'h1008, 3, 0, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    run_op(2, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 32'h100C, 1, 0, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
    run_op(2, 3'b000, 32'h201, 32'h0000003C, 5'd0, 32'h1010, 0, 0, 32'h0, 1'b0, 4'b0010, 32'h3C3C3C3C, 32'h0);

    // Loads from 0x80F17F02
    run_op(1, 3'b000, 32'h203, 32'h0, 5'd5, 32'h2004, 0, 1, 32'h80F17F02, 1'b0, 4'b0, 32'h0, 32'hFFFFFF80);
    run_op(1, 3'b100, 32'h203, 32'h0, 5'd6, 32'h2008, 0, 1, 32'h80F17F02, 1'b0, 4'b0, 32'h0, 32'h00000080);
    run_op(1, 3'b001, 32'h200, 32'h0, 5'd7, 32'h200C, 0, 1, 32'h80F17F02, 1'b0, 4'b0, 32'h0, 32'h00007F02);
    run_op(1, 3'b101, 32'h202, 32'h0, 5'd8, 32'h2010, 0, 1, 32'h80F17F02, 1'b0, 4'b0, 32'h0, 32'h000080F1);
    run_op(1, 3'b001, 32'h202, 32'h0, 5'd9, 32'h2014, 0, 0, 32'h80F17F02, 1'b0, 4'b0, 32'h0, 32'hFFFF80F1);
    run_op(1, 3'b010, 32'h100, 32'h0, 5'd10, 32'h2018, 2, 0, 32'h12345678, 1'b0, 4'b0, 32'h0, 32'h12345678);

    // Faults: misaligned LW/SH, illegal store size
    run_op(1, 3'b010, 32'h102, 32'h0, 5'd11, 32'h3004, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0);
    run_op(2, 3'b001, 32'h101, 32'h5555, 5'd0, 32'h3008, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0);
    run_op(2, 3'b100, 32'h104, 32'h5555, 5'd0, 32'h300C, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0);

    // ALU op then load; PC+4 op holds ReadDataE
    run_op(0, 3'b000, 32'h55, 32'h0, 5'd12, 32'h4004, 0, 0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    run_op(1, 3'b010, 32'h40, 32'h0, 5'd13, 32'h4008, 0, 0, 32'hCAFEF00D, 1'b0, 4'b0, 32'h0, 32'hCAFEF00D);
    run_op(3, 3'b000, 32'h77, 32'h0, 5'd1, 32'h400C, 0, 0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);

    // Reset while waiting for a load response
    RegWriteD = 1'b1; ResultSrcD = 2'b01; MemWriteD = 1'b0; PCPlus4D = 32'h5004;
    RdD = 5'd14; ALUResultD = 32'h80; Funct3D = 3'b010; dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    check_val("rsp_wait_stall", StallMemH, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rst_rw", RegWriteE, 1'b0);
    check_val("mid_rst_rdata", ReadDataE, 32'h0);
    check_val("mid_rst_alu", ALUResultE, 32'h0);
    check_val("mid_rst_stall", StallMemH, 1'b0);
    rst_n = 1'b1;
    RegWriteD = 1'b0; ResultSrcD = 2'b00; RdD = 5'd0; ALUResultD = 32'h0; PCPlus4D = 32'h0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    check_val("post_rst_stall", StallMemH, 1'b0);
    check_val("post_rst_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    check_val("post_rst_rdata", ReadDataE, 32'h0);
    check_val("post_rst_rw", RegWriteE, 1'b0);
    dmem_rvalid = 1'b0;
    last_rdata = 32'h0;

    // Recovery after reset
    run_op(1, 3'b100, 32'h301, 32'h0, 5'd15, 32'h6004, 1, 2, 32'h11223344, 1'b0, 4'b0, 32'h0, 32'h00000033);

    if (sb.size() != 0) check_val("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage RISC-V pipeline.
- Consumes the D-stage register outputs of the execute stage.
- Drives the data-memory request/response handshake with byte-lane steering for stores and extraction/extension for loads.
- Registers results into the E (writeback) stage, and stalls upstream stages while a memory transaction is outstanding.

Parameters:
DATA_WIDTH, 32, datapath/address width; only 32 supported
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
RegWriteD  in  1  register write enable from execute
ResultSrcD  in  2  result select (00 ALU, 01 load data, 10 PC+4)
MemWriteD  in  1  store enable
PCPlus4D  in  DATA_WIDTH  PC+4 passthrough
RdD  in  5  destination register
MemWriteDataD  in  DATA_WIDTH  store data (already forwarded)
ALUResultD  in  DATA_WIDTH  ALU result / effective address
Funct3D  in  3  access size/sign
ForwardALUResultDH  out  DATA_WIDTH  combinational copy of ALUResultD for hazard forwarding
StallMemH  out  1  freeze fetch/decode/execute and D registers
MemFaultH  out  1  one-cycle pulse on misaligned or illegal access
dmem_req  out  1  request valid
dmem_ready  in  1  request accepted when dmem_req & dmem_ready
dmem_we  out  1  1 = store
dmem_addr  out  DATA_WIDTH  word-aligned address ({ALUResultD[31:2],2'b00})
dmem_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_wstrb  out  STRB_WIDTH  byte enables
dmem_rvalid  in  1  load data valid
dmem_rdata  in  DATA_WIDTH  load data word
RegWriteE  out  1  writeback enable
ResultSrcE  out  2  result select passthrough
RdE  out  5  destination passthrough
PCPlus4E  out  DATA_WIDTH  PC+4 passthrough
ALUResultE  out  DATA_WIDTH  ALU result passthrough
ReadDataE  out  DATA_WIDTH  extracted/extended load data

Behaviour:
- Reset: synchronous on clk when rst_n=0.
  - State returns to IDLE and all registered outputs are 0.
  - dmem_req, StallMemH and MemFaultH are 0.
  - An outstanding transaction is abandoned; any dmem_rvalid arriving while in IDLE is ignored.
- Operation classes:
  - Load: ResultSrcD==01.
  - Store: MemWriteD=1.
  - Neither: the instruction passes to the E registers in 1 cycle with no stall.
- Legality:
  - funct3 000/100 (byte) are always aligned.
  - 001/101 (half) require addr[0]=0.
  - 010 (word) requires addr[1:0]=00.
  - Store funct3 must be 000/001/010; load funct3 must be 000/001/010/100/101.
  - A violation raises MemFaultH for 1 cycle with no request issued. The E registers load a bubble (RegWriteE=0) and there is no stall.
- FSM states:
  - IDLE: with a legal memory op present, assert dmem_req.
    - ready=1 and store: complete in this cycle.
    - ready=1 and load: go to WAIT_RSP.
    - ready=0: go to WAIT_GNT.
  - WAIT_GNT: dmem_req held and all request fields held stable until ready.
    - Store: complete on grant.
    - Load: go to WAIT_RSP on grant.
  - WAIT_RSP: dmem_req=0.
    - On dmem_rvalid, capture the extracted data into ReadDataE, complete, and return to IDLE.
    - rvalid must not be accepted in the same cycle as the grant.
- Stall and completion:
  - StallMemH = memory op present & ~completing this cycle (combinational).
  - The upstream holds D inputs stable while StallMemH=1.
  - While stalled, the E registers load a bubble (RegWriteE=0, RdE=0).
  - On completion, the E registers load the D-side values.
  - Minimum latency: store 1 cycle (ready=1), load 2 cycles.
- Store steering:
  - Byte: wdata={4{data[7:0]}}, wstrb=0001<<addr[1:0].
  - Half: wdata={2{data[15:0]}}, wstrb=0011<<addr[1:0].
  - Word: wdata=data, wstrb=1111.
  - dmem_wstrb=0 for loads.
- Load extraction:
  - Byte lane is addr[1:0] (captured at request); half lane is addr[1].
  - Sign-extended for 000/001; zero-extended for 100/101; 010 takes the full word.
- ReadDataE holds its last value for non-load completions.

Decomposition:
- Package mem_pkg holds:
  - funct3 size codes (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - ResultSrc encodings;
  - the FSM state encoding (IDLE, WAIT_GNT, WAIT_RSP).
- Sub-module load_align: combinational lane select plus sign/zero extension. Inputs: rdata, addr[1:0], funct3. Output: extended data.
- FSM, store steering and E registers live in mem_access.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ready=1 -> wstrb 1111, wdata 0xDEADBEEF, StallMemH=0, RegWriteE=0 next cycle.
- SB addr 0x103 data 0x000000A5, ready held 0 for 3 cycles -> wstrb 1000, wdata 0xA5A5A5A5, fields stable, StallMemH=1 for 3 cycles, completes on grant.
- Loads from word 0x80F1_7F02, each with ready=1 and rvalid 2 cycles later:
  - LB addr 0x203 -> ReadDataE=0xFFFFFF80.
  - LBU addr 0x203 -> 0x00000080.
  - LH addr 0x200 -> 0x00007F02.
  - LHU addr 0x202 -> 0x000080F1.
  - In each case StallMemH=1 until the rvalid cycle.
- LW addr 0x102 -> MemFaultH pulse, no dmem_req, RegWriteE=0. Likewise SH addr 0x101 -> fault.
- ADD result 0x55 followed by LW 0x40 -> ADD reaches E in 1 cycle with ALUResultE=0x55. ForwardALUResultDH tracks ALUResultD each cycle.
- rst_n=0 in WAIT_RSP, then rvalid=1 after reset -> state IDLE, outputs 0, rvalid ignored, no stall.
